addr_unit: RTL and testbench
============================

# addr_unit

Parametrised program-counter / memory-address unit for the Neander datapath. It generalises the fixed 8-bit PC + REM front end to a configurable address width and increment step, and adds a synchronous reset and a clear operation. An optional return-address stack supports CALL/RET. It sits between the control unit and the memory address port. Its REM output drives the memory directly, and its PC output feeds the control unit and debug.

## Interface
Parameters:
- AW, 8, address width in bits (≥ 4)
- STEP, 1, PC increment per INC, taken modulo 2^AW
- RESET_PC, 0, PC value after reset and after CLEAR
- STACK_DEPTH, 4, return-stack entries (≥ 2); used only with ADDR_STACK_EN

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- pc_op  in  3  PC operation: HOLD=0, INC=1, LOAD=2, CLEAR=3, CALL=4, RET=5; values 6–7 behave as HOLD
- load_addr  in  AW  target address for LOAD and CALL
- data_addr  in  AW  operand address (memory data word)
- rem_sel  in  2  REM source: PC=0, LOAD=1 (load_addr), DATA=2 (data_addr); 3 behaves as PC
- rem_load  in  1  REM write enable
- pc  out  AW  current PC
- mem_addr  out  AW  REM contents; the memory address
- stk_empty  out  1  stack holds no entries
- stk_full  out  1  stack holds STACK_DEPTH entries
- stk_err  out  1  sticky error flag; set on a push to a full stack or a pop from an empty stack

## Operation
- Reset (has priority over every other input):
  - pc=RESET_PC, mem_addr=0
  - stack pointer=0, so stk_empty=1 and stk_full=0
  - stk_err=0; stack entry contents are don't-care
- pc_op per edge:
  - HOLD: pc unchanged
  - INC: pc ← (pc+STEP) mod 2^AW; wraps silently, e.g. AW=8: 0xFF+1 → 0x00
  - LOAD: pc ← load_addr
  - CLEAR: pc ← RESET_PC; the stack is untouched
  - CALL: push (pc+STEP) mod 2^AW, then pc ← load_addr
  - RET: pc ← top of stack, then pop
- Stack boundary cases:
  - CALL when stk_full=1: no push, pc unchanged, stk_err←1
  - RET when stk_empty=1: pc unchanged, stk_err←1
  - stk_err clears only on reset
- REM:
  - When rem_load=1, REM ← the source selected by rem_sel
  - rem_sel=PC samples the pre-edge pc value, so a same-cycle INC and REM-load puts the old PC in REM
  - When rem_load=0, REM holds
- PC and REM updates are independent and may happen on the same edge.

## Timing
- Every output comes straight from a register; there are no combinational paths from inputs to outputs.
- Every operation has 1-cycle latency: inputs sampled at edge N are visible after edge N.
- Stack flags reflect the pointer after the edge. A CALL into the last free slot raises stk_full in the next cycle.
- A CALL or RET that overlaps reset is discarded.
- Back-to-back CALL/RET on consecutive cycles must work with no bubble.

## Configuration
- ADDR_STACK_EN defined:
  - the return stack and the CALL/RET operations are compiled in, as described above
- ADDR_STACK_EN undefined:
  - no stack storage
  - CALL and RET behave as HOLD
  - stk_empty ties to 1, stk_full and stk_err tie to 0
  - ports are unchanged

## Structure
- Shared package addr_pkg holds:
  - the pc_op encodings (PC_HOLD … PC_RET)
  - the rem_sel encodings (REM_PC, REM_LOAD, REM_DATA)
- One sub-module, ret_stack:
  - parameterised by AW and STACK_DEPTH
  - inputs push, pop and push data; outputs top, empty, full
  - instantiated only under ADDR_STACK_EN
- The PC incrementer is inline arithmetic, not a separate instance.

## Test plan
- Reset, then 3 cycles of INC (AW=8, STEP=1): pc = 0x00, 0x01, 0x02, 0x03. With rem_sel=PC and rem_load=1 every cycle, mem_addr lags by one value.
- pc=0xFE, INC twice: pc = 0xFF, then 0x00. stk_err stays 0.
- LOAD with load_addr=0x40, then rem_sel=DATA with data_addr=0x85 and rem_load=1: pc=0x40 and mem_addr=0x85 after the second edge.
- ADDR_STACK_EN, STACK_DEPTH=2, pc=0x10:
  - CALL 0x20: pc=0x20
  - CALL 0x30: pc=0x30, stk_full=1
  - CALL 0x50: pc stays 0x30, stk_err=1
  - RET: pc=0x21
  - RET: pc=0x11, stk_empty=1
- From reset, RET on an empty stack: pc stays 0x00 and stk_err=1. Then assert reset for one cycle: stk_err=0.
- Assert reset on the same edge as CALL 0x77 with pc=0x12: pc=RESET_PC, stk_empty=1, mem_addr=0.

Source files
------------

// File: rtl/addr_pkg.sv
// addr_pkg: shared encodings for the Neander program-counter / memory-address unit.
//   pc_op_e  : PC operation codes driven by the control unit (6..7 decode as HOLD)
//   rem_sel_e: REM source select codes (3 decodes as PC)
package addr_pkg;

  localparam int unsigned PC_OP_W   = 3;
  localparam int unsigned REM_SEL_W = 2;

  typedef enum logic [PC_OP_W-1:0] {
    PC_HOLD  = 3'd0,
    PC_INC   = 3'd1,
    PC_LOAD  = 3'd2,
    PC_CLEAR = 3'd3,
    PC_CALL  = 3'd4,
    PC_RET   = 3'd5
  } pc_op_e;

  typedef enum logic [REM_SEL_W-1:0] {
    REM_PC   = 2'd0,
    REM_LOAD = 2'd1,
    REM_DATA = 2'd2
  } rem_sel_e;

endpackage

// File: rtl/addr_unit_if.sv
// addr_unit_if: control-unit <-> address-unit bus.
//   master (control unit): drives pc_op, load_addr, data_addr, rem_sel, rem_load;
//                          observes pc, mem_addr, stk_empty, stk_full, stk_err
//   slave  (addr_unit)   : the reverse
interface addr_unit_if
  import addr_pkg::*;
#(
  parameter int unsigned AW = 8
);

  logic [PC_OP_W-1:0]   pc_op;
  logic [AW-1:0]        load_addr;
  logic [AW-1:0]        data_addr;
  logic [REM_SEL_W-1:0] rem_sel;
  logic                 rem_load;
  logic [AW-1:0]        pc;
  logic [AW-1:0]        mem_addr;
  logic                 stk_empty;
  logic                 stk_full;
  logic                 stk_err;

  modport master (
    output pc_op, load_addr, data_addr, rem_sel, rem_load,
    input  pc, mem_addr, stk_empty, stk_full, stk_err
  );

  modport slave (
    input  pc_op, load_addr, data_addr, rem_sel, rem_load,
    output pc, mem_addr, stk_empty, stk_full, stk_err
  );

endinterface

// File: rtl/addr_unit_ret_stack.sv
// ret_stack: LIFO of return addresses for CALL/RET.
//   clock, reset : rising-edge clock, synchronous active-high reset (empties the stack)
//   push, pop    : one operation per edge; caller guarantees no push when full / pop when empty
//   push_data    : address pushed on push
//   top          : most recently pushed entry (don't-care when empty)
//   empty, full  : decoded from the registered stack pointer
module ret_stack #(
  parameter int unsigned AW          = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full
);

  localparam int unsigned PW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IW = $clog2(STACK_DEPTH);

  logic [PW-1:0] sp;
  logic [AW-1:0] mem [STACK_DEPTH];

  // Stack pointer: number of valid entries.
  always_ff @(posedge clock) begin
    if (reset) begin
      sp <= '0;
    end else if (push) begin
      sp <= sp + PW'(1);
    end else if (pop) begin
      sp <= sp - PW'(1);
    end
  end

  // Entry storage needs no reset; contents behind sp are never observed.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem[IW'(sp)] <= push_data;
    end
  end

  assign top   = mem[IW'(sp - PW'(1))];
  assign empty = (sp == '0);
  assign full  = (sp == PW'(STACK_DEPTH));

endmodule

// File: rtl/addr_unit.sv
// addr_unit: parameterised PC + REM front end of the Neander datapath.
//   clock : rising-edge clock
//   reset : synchronous active-high reset (priority over all other inputs)
//   bus   : addr_unit_if.slave -- pc_op, load_addr, data_addr, rem_sel, rem_load in;
//           pc, mem_addr, stk_empty, stk_full, stk_err out (all from registers)
// Optional feature macro: ADDR_STACK_EN compiles in the return stack and CALL/RET.
// Without it CALL/RET decode as HOLD and the stack flags are tied (empty=1, full=0, err=0).
module addr_unit
  import addr_pkg::*;
#(
  parameter int unsigned AW          = 8,
  parameter int unsigned STEP        = 1,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  addr_unit_if.slave   bus
);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] rem_q;
  logic [AW-1:0] rem_next;
  logic          err_set;

  // Incrementer wraps modulo 2^AW by truncation.
  assign pc_inc = pc_q + AW'(STEP);

`ifdef ADDR_STACK_EN
  logic          stk_push;
  logic          stk_pop;
  logic [AW-1:0] stk_top;
  logic          stk_empty_w;
  logic          stk_full_w;
  logic          err_q;

  // Illegal push/pop are suppressed here so the stack never over/underflows.
  assign stk_push = (bus.pc_op == PC_CALL) && !stk_full_w;
  assign stk_pop  = (bus.pc_op == PC_RET)  && !stk_empty_w;

  ret_stack #(
    .AW          (AW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .empty     (stk_empty_w),
    .full      (stk_full_w)
  );
`endif

  // Next PC and stack-error detection.
  always_comb begin
    pc_next = pc_q;
    err_set = 1'b0;
    case (bus.pc_op)
      PC_INC:   pc_next = pc_inc;
      PC_LOAD:  pc_next = bus.load_addr;
      PC_CLEAR: pc_next = AW'(RESET_PC);
`ifdef ADDR_STACK_EN
      PC_CALL: begin
        if (stk_full_w) err_set = 1'b1;
        else            pc_next = bus.load_addr;
      end
      PC_RET: begin
        if (stk_empty_w) err_set = 1'b1;
        else             pc_next = stk_top;
      end
`endif
      default: pc_next = pc_q;
    endcase
  end

  // REM source; PC selection uses the pre-edge PC.
  always_comb begin
    rem_next = pc_q;
    case (bus.rem_sel)
      REM_LOAD: rem_next = bus.load_addr;
      REM_DATA: rem_next = bus.data_addr;
      default:  rem_next = pc_q;
    endcase
  end

  // PC and REM registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= AW'(RESET_PC);
      rem_q <= '0;
    end else begin
      pc_q <= pc_next;
      if (bus.rem_load) begin
        rem_q <= rem_next;
      end
    end
  end

`ifdef ADDR_STACK_EN
  // Sticky stack error, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign bus.stk_empty = stk_empty_w;
  assign bus.stk_full  = stk_full_w;
  assign bus.stk_err   = err_q;
`else
  assign bus.stk_empty = 1'b1;
  assign bus.stk_full  = 1'b0;
  assign bus.stk_err   = err_set;
`endif

  assign bus.pc       = pc_q;
  assign bus.mem_addr = rem_q;

endmodule

// File: tb/tb_addr_unit.sv
// tb_addr_unit: directed, table-driven bench for addr_unit (AW=8, STEP=1, RESET_PC=0, STACK_DEPTH=2).
// Stack expectations follow ADDR_STACK_EN the same way the design does.
module tb_addr_unit;
  import addr_pkg::*;

  localparam int unsigned AW = 8;

  logic clock = 1'b0;
  logic reset;

  addr_unit_if #(.AW(AW)) bus ();

  addr_unit #(
    .AW          (AW),
    .STEP        (1),
    .RESET_PC    (0),
    .STACK_DEPTH (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] op;
    logic [7:0] la;
    logic [7:0] da;
    logic [1:0] sel;
    logic       rl;
    logic [7:0] e_pc;
    logic [7:0] e_mem;
    logic       e_empty;
    logic       e_full;
    logic       e_err;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs, clock one edge, sample 1 time unit after the edge.
  task automatic cyc(input logic rst, input logic [2:0] op, input logic [7:0] la,
                     input logic [7:0] da, input logic [1:0] sel, input logic rl);
    reset         = rst;
    bus.pc_op     = op;
    bus.load_addr = la;
    bus.data_addr = da;
    bus.rem_sel   = sel;
    bus.rem_load  = rl;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [7:0] pc, input logic [7:0] mem,
                         input logic e, input logic f, input logic err);
    chk({name, ".pc"},        32'(bus.pc),        32'(pc));
    chk({name, ".mem_addr"},  32'(bus.mem_addr),  32'(mem));
    chk({name, ".stk_empty"}, 32'(bus.stk_empty), 32'(e));
    chk({name, ".stk_full"},  32'(bus.stk_full),  32'(f));
    chk({name, ".stk_err"},   32'(bus.stk_err),   32'(err));
  endtask

  function automatic vec_t mk(input string n, input logic r, input logic [2:0] op,
                              input logic [7:0] la, input logic [7:0] da,
                              input logic [1:0] sel, input logic rl,
                              input logic [7:0] pc, input logic [7:0] mem);
    vec_t v;
    v.name = n; v.rst = r; v.op = op; v.la = la; v.da = da; v.sel = sel; v.rl = rl;
    v.e_pc = pc; v.e_mem = mem; v.e_empty = 1'b1; v.e_full = 1'b0; v.e_err = 1'b0;
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    bus.pc_op = PC_HOLD; bus.load_addr = '0; bus.data_addr = '0;
    bus.rem_sel = REM_PC; bus.rem_load = 1'b0;
    #2;

    // Each row is one clock edge; rows depend on the preceding state.
    vecs.push_back(mk("reset",      1, PC_HOLD,  8'h00, 8'h00, REM_PC,   1, 8'h00, 8'h00));
    vecs.push_back(mk("inc1",       0, PC_INC,   8'h00, 8'h00, REM_PC,   1, 8'h01, 8'h00));
    vecs.push_back(mk("inc2",       0, PC_INC,   8'h00, 8'h00, REM_PC,   1, 8'h02, 8'h01));
    vecs.push_back(mk("inc3",       0, PC_INC,   8'h00, 8'h00, REM_PC,   1, 8'h03, 8'h02));
    vecs.push_back(mk("load_fe",    0, PC_LOAD,  8'hFE, 8'h00, REM_PC,   0, 8'hFE, 8'h02));
    vecs.push_back(mk("inc_ff",     0, PC_INC,   8'h00, 8'h00, REM_PC,   0, 8'hFF, 8'h02));
    vecs.push_back(mk("inc_wrap",   0, PC_INC,   8'h00, 8'h00, REM_PC,   0, 8'h00, 8'h02));
    vecs.push_back(mk("load_40",    0, PC_LOAD,  8'h40, 8'h00, REM_PC,   0, 8'h40, 8'h02));
    vecs.push_back(mk("rem_data",   0, PC_HOLD,  8'h00, 8'h85, REM_DATA, 1, 8'h40, 8'h85));
    vecs.push_back(mk("op6_remld",  0, 3'd6,     8'h33, 8'h00, REM_LOAD, 1, 8'h40, 8'h33));
    vecs.push_back(mk("op7_sel3",   0, 3'd7,     8'h00, 8'h00, 2'd3,     1, 8'h40, 8'h40));
    vecs.push_back(mk("rem_hold",   0, PC_INC,   8'h00, 8'h99, REM_DATA, 0, 8'h41, 8'h40));
    vecs.push_back(mk("inc_rem_pc", 0, PC_INC,   8'h00, 8'h00, REM_PC,   1, 8'h42, 8'h41));
    vecs.push_back(mk("clear",      0, PC_CLEAR, 8'h00, 8'h00, REM_PC,   0, 8'h00, 8'h41));
    vecs.push_back(mk("load_55",    0, PC_LOAD,  8'h55, 8'h00, REM_LOAD, 1, 8'h55, 8'h55));
    vecs.push_back(mk("rst_prio",   1, PC_LOAD,  8'h66, 8'h00, REM_LOAD, 1, 8'h00, 8'h00));

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].op, vecs[i].la, vecs[i].da, vecs[i].sel, vecs[i].rl);
      chk_all(vecs[i].name, vecs[i].e_pc, vecs[i].e_mem,
              vecs[i].e_empty, vecs[i].e_full, vecs[i].e_err);
    end

`ifdef ADDR_STACK_EN
    // Return stack fill / overflow / drain with back-to-back CALL and RET.
    cyc(0, PC_LOAD, 8'h10, 8'h00, REM_PC, 0); chk_all("stk_load10", 8'h10, 8'h00, 1, 0, 0);
    cyc(0, PC_CALL, 8'h20, 8'h00, REM_PC, 0); chk_all("call20",     8'h20, 8'h00, 0, 0, 0);
    cyc(0, PC_CALL, 8'h30, 8'h00, REM_PC, 0); chk_all("call30",     8'h30, 8'h00, 0, 1, 0);
    cyc(0, PC_CALL, 8'h50, 8'h00, REM_PC, 0); chk_all("call_full",  8'h30, 8'h00, 0, 1, 1);
    cyc(0, PC_RET,  8'h00, 8'h00, REM_PC, 0); chk_all("ret1",       8'h21, 8'h00, 0, 0, 1);
    cyc(0, PC_RET,  8'h00, 8'h00, REM_PC, 0); chk_all("ret2",       8'h11, 8'h00, 1, 0, 1);
    // Underflow from reset, then reset clears the sticky error.
    cyc(1, PC_HOLD, 8'h00, 8'h00, REM_PC, 0); chk_all("rst_a",      8'h00, 8'h00, 1, 0, 0);
    cyc(0, PC_RET,  8'h00, 8'h00, REM_PC, 0); chk_all("ret_empty",  8'h00, 8'h00, 1, 0, 1);
    cyc(1, PC_HOLD, 8'h00, 8'h00, REM_PC, 0); chk_all("err_clr",    8'h00, 8'h00, 1, 0, 0);
    // CALL overlapping reset is discarded.
    cyc(0, PC_LOAD, 8'h12, 8'hAA, REM_DATA, 1); chk_all("load12",   8'h12, 8'hAA, 1, 0, 0);
    cyc(1, PC_CALL, 8'h77, 8'h00, REM_PC, 0); chk_all("rst_call",   8'h00, 8'h00, 1, 0, 0);
    cyc(0, PC_RET,  8'h00, 8'h00, REM_PC, 0); chk_all("ret_after",  8'h00, 8'h00, 1, 0, 1);
`else
    // Without the stack, CALL/RET are HOLD and the flags stay tied.
    cyc(0, PC_LOAD, 8'h10, 8'h00, REM_PC, 0); chk_all("stk_load10", 8'h10, 8'h00, 1, 0, 0);
    cyc(0, PC_CALL, 8'h20, 8'h00, REM_PC, 0); chk_all("call_hold",  8'h10, 8'h00, 1, 0, 0);
    cyc(0, PC_CALL, 8'h30, 8'h00, REM_PC, 0); chk_all("call_hold2", 8'h10, 8'h00, 1, 0, 0);
    cyc(0, PC_RET,  8'h00, 8'h00, REM_PC, 0); chk_all("ret_hold",   8'h10, 8'h00, 1, 0, 0);
    cyc(0, PC_LOAD, 8'h12, 8'hAA, REM_DATA, 1); chk_all("load12",   8'h12, 8'hAA, 1, 0, 0);
    cyc(1, PC_CALL, 8'h77, 8'h00, REM_PC, 0); chk_all("rst_call",   8'h00, 8'h00, 1, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
